ram_burst_master: RTL and testbench
===================================

Name: ram_burst_master

Overview:
- Initiator-side controller for the single-port synchronous RAM: it owns the RAM's Din/ADDR/EN/WE pins and consumes its Dout.
- Accepts burst commands (start address, word count, direction) over a valid/ready handshake.
- Write bursts move words from a valid/ready write stream into consecutive RAM locations. Read bursts fetch consecutive locations and present them on a valid/ready read stream.
- Sits between datapath/test logic and the RAM so that no other block drives RAM pins directly.

Parameters:
- ADDR_WIDTH, 8, RAM address width; burst addresses wrap modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 10, RAM word width; width of all data paths.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  controller idle, accepts command.
- cmd_write  input  1  1 = write burst, 0 = read burst.
- cmd_addr  input  ADDR_WIDTH  burst start address.
- cmd_len  input  ADDR_WIDTH  word count minus one (0 = 1 word, all-ones = 2^ADDR_WIDTH words).
- wr_data  input  DATA_WIDTH  write stream data.
- wr_valid  input  1  write word offered.
- wr_ready  output  1  write word accepted this cycle when wr_valid is also high.
- rd_data  output  DATA_WIDTH  read stream data.
- rd_valid  output  1  rd_data valid.
- rd_ready  input  1  consumer takes rd_data.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse at burst completion.
- mem_din  output  DATA_WIDTH  to RAM Din.
- mem_addr  output  ADDR_WIDTH  to RAM ADDR.
- mem_en  output  1  to RAM EN.
- mem_we  output  1  to RAM WE.
- mem_dout  input  DATA_WIDTH  from RAM Dout.

Behaviour:
- RAM contract:
  - Write occurs at the CLK edge where mem_en=1 and mem_we=1.
  - Read: mem_en=1 and mem_we=0 at edge N gives mem_dout valid after edge N, sampled at edge N+1.
- Single clock. RST is synchronous and active-high.
- Reset, including mid-burst:
  - State goes to IDLE; the burst is abandoned with no done pulse.
  - cmd_ready=1 in IDLE. busy, done, rd_valid, wr_ready, mem_en and mem_we are 0.
  - mem_addr, mem_din and rd_data are 0.
  - cur_addr and remaining are cleared.
- States: IDLE, WRITE, RD_ISSUE, RD_CAPTURE, RD_OUT.
- IDLE:
  - cmd_ready=1, busy=0.
  - On cmd_valid: latch cur_addr=cmd_addr and remaining=cmd_len.
  - Go to WRITE if cmd_write=1, else RD_ISSUE.
- WRITE:
  - wr_ready=1.
  - mem_en = mem_we = wr_valid, mem_addr=cur_addr, mem_din=wr_data, all combinational from state and registers.
  - Per accepted word: if remaining==0, go to IDLE and pulse done on the next cycle. Otherwise cur_addr+1 (wraps) and remaining-1.
  - A cycle with no wr_valid issues no RAM access.
- RD_ISSUE: mem_en=1, mem_we=0, mem_addr=cur_addr; go to RD_CAPTURE.
- RD_CAPTURE: mem_en=0; register rd_data<=mem_dout; go to RD_OUT.
- RD_OUT:
  - rd_valid=1. rd_data stays stable until rd_ready.
  - On rd_ready: if remaining==0, go to IDLE with done. Otherwise cur_addr+1 (wraps), remaining-1, go to RD_ISSUE.
- Read throughput: 1 word per 3 cycles with rd_ready held high. First rd_valid appears 3 cycles after command acceptance.
- busy=1 in every non-IDLE state. done is registered: high for exactly the cycle after the last beat handshake, which is also the first IDLE cycle.
- cmd_ready=0 outside IDLE; commands offered then are not accepted. wr_ready=0 outside WRITE. rd_valid=0 outside RD_OUT.
- A command is accepted on the same cycle that done is high.
- Address wrap: 0xFF+1 = 0x00 (ADDR_WIDTH=8). The all-ones cmd_len covers every location exactly once.
- mem_we is never 1 unless mem_en is 1. No RAM access in IDLE.

Test Plan:
- Single write then read:
  - cmd write addr=0x10 len=0, wr_data=0x2A5 → exactly one mem_en&mem_we cycle at 0x10, then done pulse.
  - cmd read 0x10 len=0 → rd_valid with rd_data=0x2A5 three cycles after accept, done after rd_ready.
- Burst with wrap:
  - write addr=0xFE len=3, data 1,2,3,4 → writes hit 0xFE, 0xFF, 0x00, 0x01.
  - Read back same range → 1,2,3,4 in order.
- Backpressure:
  - Write: wr_valid toggled 1/0 → no RAM write in gap cycles, 4 writes total.
  - Read: rd_ready held low 5 cycles → rd_data and rd_valid stable, no new mem_en issued.
- Full-memory burst: write len=0xFF with data=address → 256 writes, then 256 reads match, exactly one done each.
- Reset mid-burst: assert RST after 2 of 4 write words → next cycle IDLE, cmd_ready=1, no done, outputs at reset values; a new command is accepted normally.
- Command interlock: cmd_valid held during a busy burst → not accepted until done. Back-to-back command accepted on the done cycle.

Source files
------------

// File: rtl/ram_burst_master_if.sv
`default_nettype none
// ============================================================================
//  Module   : ram_burst_master_if
//  Purpose  : Groups the command, write-stream, read-stream, status and RAM
//             pin signals of the burst master into one bundle.
//  Revision : 1.0 - initial release
// ============================================================================
interface ram_burst_master_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 10
);
    // Command channel
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [ADDR_WIDTH-1:0] cmd_len;
    // Write stream
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_valid;
    logic                  wr_ready;
    // Read stream
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  rd_ready;
    // Status
    logic                  busy;
    logic                  done;
    // RAM pins
    logic [DATA_WIDTH-1:0] mem_din;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_en;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_dout;

    // Controller side
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wr_data, wr_valid, rd_ready, mem_dout,
        output cmd_ready, wr_ready, rd_data, rd_valid, busy, done,
        output mem_din, mem_addr, mem_en, mem_we
    );

    // Environment side (command source, streams and the RAM itself)
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wr_data, wr_valid, rd_ready, mem_dout,
        input  cmd_ready, wr_ready, rd_data, rd_valid, busy, done,
        input  mem_din, mem_addr, mem_en, mem_we
    );
endinterface
`default_nettype wire

// File: rtl/ram_burst_master.sv
`default_nettype none
// ============================================================================
//  Module   : ram_burst_master
//  Purpose  : Sole initiator of a single-port synchronous RAM. Executes
//             write bursts from a valid/ready stream and read bursts onto a
//             valid/ready stream, one word address per beat, wrapping.
//  Revision : 1.0 - initial release
// ============================================================================
module ram_burst_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 10
) (
    input  wire logic            CLK,
    input  wire logic            RST,
    ram_burst_master_if.master   bus
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WRITE      = 3'd1,
        S_RD_ISSUE   = 3'd2,
        S_RD_CAPTURE = 3'd3,
        S_RD_OUT     = 3'd4
    } state_t;

    state_t                state_q,     state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q,  cur_addr_d;
    logic [ADDR_WIDTH-1:0] remaining_q, remaining_d;
    logic [DATA_WIDTH-1:0] rd_data_q,   rd_data_d;
    logic                  done_q,      done_d;

    // State and datapath registers; reset abandons any burst without done
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            rd_data_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            rd_data_q   <= rd_data_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic and RAM/stream outputs decoded from the current state
    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        remaining_d  = remaining_q;
        rd_data_d    = rd_data_q;
        done_d       = 1'b0;

        bus.cmd_ready = 1'b0;
        bus.busy      = 1'b1;
        bus.wr_ready  = 1'b0;
        bus.rd_valid  = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = cur_addr_q;
        bus.mem_din   = '0;

        case (state_q)
            S_IDLE: begin
                bus.cmd_ready = 1'b1;
                bus.busy      = 1'b0;
                if (bus.cmd_valid) begin
                    cur_addr_d  = bus.cmd_addr;
                    remaining_d = bus.cmd_len;
                    state_d     = bus.cmd_write ? S_WRITE : S_RD_ISSUE;
                end
            end
            S_WRITE: begin
                // The RAM write strobe follows wr_valid directly, so an
                // idle stream cycle never touches the RAM.
                bus.wr_ready = 1'b1;
                bus.mem_en   = bus.wr_valid;
                bus.mem_we   = bus.wr_valid;
                bus.mem_din  = bus.wr_data;
                if (bus.wr_valid) begin
                    if (remaining_q == '0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cur_addr_d  = cur_addr_q + ADDR_WIDTH'(1);
                        remaining_d = remaining_q - ADDR_WIDTH'(1);
                    end
                end
            end
            S_RD_ISSUE: begin
                bus.mem_en = 1'b1;
                state_d    = S_RD_CAPTURE;
            end
            S_RD_CAPTURE: begin
                // RAM output is valid this cycle; hold it locally so it stays
                // stable for as long as the consumer stalls.
                rd_data_d = bus.mem_dout;
                state_d   = S_RD_OUT;
            end
            S_RD_OUT: begin
                bus.rd_valid = 1'b1;
                if (bus.rd_ready) begin
                    if (remaining_q == '0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cur_addr_d  = cur_addr_q + ADDR_WIDTH'(1);
                        remaining_d = remaining_q - ADDR_WIDTH'(1);
                        state_d     = S_RD_ISSUE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered stream data and completion pulse
    assign bus.rd_data = rd_data_q;
    assign bus.done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_burst_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_burst_master
//  Purpose  : Scoreboard bench for ram_burst_master with a behavioural RAM,
//             a reference memory image and randomised bursts.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram_burst_master;

    localparam int AW = 8;
    localparam int DW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_burst_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ram_burst_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    // Behavioural single-port synchronous RAM
    logic [DW-1:0] ram [0:255];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
            else            bus.mem_dout      <= ram[bus.mem_addr];
        end
    end

    // Scoreboard state
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [AW-1:0] exp_waddr_q [$];
    logic [DW-1:0] exp_wdata_q [$];
    logic [DW-1:0] exp_rd_q    [$];
    int            burst_q     [$];
    logic [DW-1:0] model_mem   [0:255];
    logic [DW-1:0] wdata       [0:255];

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic abort(input string name);
        n_fail++;
        $display("FAIL %s: timeout (t=%0t)", name, $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    // Monitor: compares every RAM write, read beat and done pulse
    int cur_left = 0;
    bit done_exp = 1'b0;
    bit done_now;
    bit beat;
    always @(negedge clk) begin
        if (rst) begin
            exp_waddr_q.delete();
            exp_wdata_q.delete();
            exp_rd_q.delete();
            burst_q.delete();
            cur_left = 0;
            done_exp = 1'b0;
        end else begin
            done_now = done_exp;
            done_exp = 1'b0;
            if (bus.done || done_now) check("done_pulse", bus.done, done_now);
            if (bus.mem_we && !bus.mem_en) check("we_implies_en", bus.mem_en, 1);
            if (bus.mem_en && bus.mem_we) begin
                if (exp_waddr_q.size() == 0) begin
                    check("unexpected_write_addr", bus.mem_addr, 32'hFFFF_FFFF);
                end else begin
                    check("wr_addr", bus.mem_addr, exp_waddr_q[0]);
                    check("wr_data", bus.mem_din,  exp_wdata_q[0]);
                    model_mem[exp_waddr_q[0]] = exp_wdata_q[0];
                    void'(exp_waddr_q.pop_front());
                    void'(exp_wdata_q.pop_front());
                end
            end
            if (bus.rd_valid && bus.rd_ready) begin
                if (exp_rd_q.size() == 0) check("unexpected_rd_beat", bus.rd_data, 32'hFFFF_FFFF);
                else check("rd_data", bus.rd_data, exp_rd_q.pop_front());
            end
            beat = (bus.wr_valid && bus.wr_ready) || (bus.rd_valid && bus.rd_ready);
            if (beat) begin
                if (cur_left == 0) begin
                    if (burst_q.size() == 0) check("beat_without_cmd", 1, 0);
                    else cur_left = burst_q.pop_front();
                end
                if (cur_left > 0) begin
                    cur_left--;
                    if (cur_left == 0) done_exp = 1'b1;
                end
            end
        end
    end

    // Offer a command until accepted, then record what the burst must do
    task automatic send_cmd(input bit w, input int addr, input int len, input bit chk_done);
        int t = 0;
        logic [AW-1:0] a;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = AW'(addr);
        bus.cmd_len   = AW'(len);
        forever begin
            @(negedge clk);
            if (bus.cmd_ready) break;
            t++;
            if (t > 3000) abort("cmd_accept");
        end
        if (chk_done) check("b2b_on_done", bus.done, 1);
        burst_q.push_back(len + 1);
        for (int i = 0; i <= len; i++) begin
            a = AW'(addr + i);
            if (w) begin
                exp_waddr_q.push_back(a);
                exp_wdata_q.push_back(wdata[i]);
            end else begin
                exp_rd_q.push_back(model_mem[a]);
            end
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    // mode 0: always valid, 1: toggled, 2: random gaps
    task automatic write_data(input int len, input int mode, input bit chk_blocked,
                              input int stop_at);
        int acc = 0;
        int cyc = 0;
        while (acc <= len && acc < stop_at) begin
            bus.wr_data = wdata[acc];
            case (mode)
                0:       bus.wr_valid = 1'b1;
                1:       bus.wr_valid = (cyc % 2 == 0);
                default: bus.wr_valid = ($urandom_range(0, 2) != 0);
            endcase
            @(negedge clk);
            if (chk_blocked) check("cmd_blocked_busy", bus.cmd_ready, 0);
            if (bus.wr_valid && bus.wr_ready) acc++;
            @(posedge clk); #1;
            cyc++;
            if (cyc > 5000) abort("write_stream");
        end
        bus.wr_valid = 1'b0;
    endtask

    // mode 0: always ready, 1: random ready, 2: stall 5 cycles on first word
    task automatic read_data(input int len, input int mode, input bit chk_lat);
        int got = 0;
        int cyc = 0;
        bit first = 1'b1;
        bit stall_done = 1'b0;
        logic [DW-1:0] held;
        while (got <= len) begin
            bus.rd_ready = (mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (mode == 2 && !stall_done) bus.rd_ready = 1'b0;
            @(negedge clk);
            cyc++;
            if (bus.rd_valid && first) begin
                first = 1'b0;
                if (chk_lat) check("rd_first_latency", cyc, 3);
                if (mode == 2) begin
                    held = bus.rd_data;
                    for (int k = 0; k < 5; k++) begin
                        @(posedge clk); #1;
                        @(negedge clk);
                        check("stall_rd_valid", bus.rd_valid, 1);
                        check("stall_rd_data", bus.rd_data, held);
                        check("stall_no_mem_en", bus.mem_en, 0);
                    end
                    stall_done = 1'b1;
                end
            end
            if (bus.rd_valid && bus.rd_ready) got++;
            @(posedge clk); #1;
            if (cyc > 5000) abort("read_stream");
        end
        bus.rd_ready = 1'b0;
    endtask

    task automatic check_reset_vals();
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_busy",      bus.busy,      0);
        check("rst_done",      bus.done,      0);
        check("rst_wr_ready",  bus.wr_ready,  0);
        check("rst_rd_valid",  bus.rd_valid,  0);
        check("rst_mem_en",    bus.mem_en,    0);
        check("rst_mem_we",    bus.mem_we,    0);
        check("rst_mem_addr",  bus.mem_addr,  0);
        check("rst_mem_din",   bus.mem_din,   0);
        check("rst_rd_data",   bus.rd_data,   0);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.wr_data   = '0;
        bus.wr_valid  = 1'b0;
        bus.rd_ready  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals();
        @(posedge clk); #1;
        rst = 1'b0;

        // Full-memory burst with data = address, then read everything back
        for (int i = 0; i < 256; i++) wdata[i] = DW'(i);
        send_cmd(1'b1, 0, 255, 1'b0);
        write_data(255, 0, 1'b0, 1000);
        send_cmd(1'b0, 0, 255, 1'b0);
        read_data(255, 0, 1'b0);

        // Single word write then read with latency check
        wdata[0] = 10'h2A5;
        send_cmd(1'b1, 'h10, 0, 1'b0);
        write_data(0, 0, 1'b0, 1000);
        send_cmd(1'b0, 'h10, 0, 1'b0);
        read_data(0, 0, 1'b1);

        // Wrapping burst, toggled write stream, stalled read
        for (int i = 0; i < 4; i++) wdata[i] = DW'(i + 1);
        send_cmd(1'b1, 'hFE, 3, 1'b0);
        write_data(3, 1, 1'b0, 1000);
        send_cmd(1'b0, 'hFE, 3, 1'b0);
        read_data(3, 2, 1'b0);

        // Command interlock: read held pending during a write burst
        for (int i = 0; i < 3; i++) wdata[i] = DW'($urandom);
        send_cmd(1'b1, 'h40, 2, 1'b0);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 8'h40;
        bus.cmd_len   = 8'd2;
        write_data(2, 0, 1'b1, 1000);
        send_cmd(1'b0, 'h40, 2, 1'b1);
        read_data(2, 0, 1'b0);

        // Reset after two of four write words
        for (int i = 0; i < 4; i++) wdata[i] = DW'($urandom);
        send_cmd(1'b1, 'h80, 3, 1'b0);
        write_data(3, 0, 1'b0, 2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals();
        @(posedge clk); #1;
        send_cmd(1'b0, 'h80, 3, 1'b0);
        read_data(3, 1, 1'b0);

        // Randomised bursts
        for (int n = 0; n < 40; n++) begin
            int w;
            int addr;
            int len;
            w    = $urandom_range(0, 1);
            addr = $urandom_range(0, 255);
            len  = $urandom_range(0, 15);
            if (w != 0) begin
                for (int i = 0; i <= len; i++) wdata[i] = DW'($urandom);
                send_cmd(1'b1, addr, len, 1'b0);
                write_data(len, 2, 1'b0, 1000);
            end else begin
                send_cmd(1'b0, addr, len, 1'b0);
                read_data(len, 1, 1'b0);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("wr_queue_drained", exp_waddr_q.size(), 0);
        check("rd_queue_drained", exp_rd_q.size(), 0);
        check("bursts_drained", burst_q.size() + cur_left, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
